loba_acc: RTL
=============

# loba_acc

Frame accumulator that sits directly downstream of the leading-one-based approximate multiplier (`loba0`). It consumes the 2N-bit approximate products over a valid/ready handshake and sums up to LEN products per frame. It then presents the frame sum and the term count on a registered valid/ready output, for dot-product and filter-tap use. Frames close on the LEN-th product or on an early `in_last`, whichever comes first.

## Interface
- `N`, 16: operand width of the upstream multiplier; products are 2N bits.
- `LEN`, 8: maximum products per frame, ≥1.
- `CW`, derived = clog2(LEN+1): width of the count field.
- `AW`, derived = 2N + clog2(LEN), minimum 2N: accumulator width. Sized so that no overflow is possible.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `in_valid` input 1: a product is present.
- `in_ready` output 1: the block can accept a product.
- `in_p` input 2N: unsigned approximate product from the multiplier.
- `in_last` input 1: this product closes the frame. Sampled only on an accepted beat.
- `out_valid` output 1: frame result is held.
- `out_ready` input 1: downstream takes the result.
- `out_sum` output AW: unsigned sum of the frame's products.
- `out_cnt` output CW: number of products in the frame, 1..LEN.

## Operation
- States: ACC and DONE. Encoding lives in the package.
- Reset (`rst_n`=0 at a clock edge):
  - state goes to ACC;
  - accumulator, count, `out_sum` and `out_cnt` go to 0;
  - `out_valid` goes to 0;
  - `in_ready` reads 1 after the edge.
- ACC:
  - `in_ready`=1 and `out_valid`=0.
  - An accept is `in_valid & in_ready`. On an accept: acc ← acc + zero-extended `in_p`, and cnt ← cnt+1.
  - If the accepted beat has `in_last`=1, or cnt+1 = LEN:
    - `out_sum` ← acc + `in_p`;
    - `out_cnt` ← cnt+1;
    - acc and cnt clear to 0;
    - state goes to DONE.
- DONE:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum` and `out_cnt` stay stable until `out_ready`=1, at which point state returns to ACC.
  - `in_valid` is ignored; no beat is accepted.
- `in_ready` is a pure function of state (Moore). `out_valid` does not depend combinationally on `out_ready`.
- Arithmetic is unsigned and exact. No saturation or wrap is reachable, because AW covers LEN·(2^2N−1).
- An empty frame is impossible: a frame always contains at least one product.
- `in_p` = 0 counts as a term. A zero product increments cnt.
- `out_sum` and `out_cnt` keep their last values after a handshake, until the next frame closes.

## Timing
- Latency: the final accepted beat at edge t gives `out_valid`=1 from edge t through the cycle after t.
- `out_valid` and the final `out_sum` become visible in the cycle after the last beat.
- Throughput: one product per cycle within a frame. There is at least 1 dead input cycle per frame (the DONE state), more if `out_ready` is held low.
- Output handshake: DONE at edge t with `out_ready`=1 means ACC after t, and the next product can be accepted in the following cycle.
- Reset mid-frame discards the partial sum. Reset in DONE drops the pending result with no handshake. Reset has priority over any accept or handshake in the same cycle.
- A beat with both `in_last` and cnt+1 = LEN closes the frame once, with the same result either way.

## Structure
- Shared package `loba_pkg`:
  - state enum (ACC, DONE);
  - `clog2` function;
  - localparam helpers for AW and CW, shared with the multiplier's width constants.
- Single module. The counter and adder are inline; no sub-module is warranted.
- The multiplier itself is not instantiated here. The top level wires the multiplier's product P to `in_p`.

## Test plan
- N=16, LEN=4. Reset, then four back-to-back beats `in_p`=10,20,30,40 with `in_last`=0 and `out_ready`=1.
  - Expect `out_valid` one cycle after beat 4, with `out_sum`=100 and `out_cnt`=4.
  - Expect `in_ready`=0 for exactly 1 cycle.
- Early close: beats 0xFFFF_FFFF then 5 with `in_last`=1 on the second beat.
  - Expect `out_sum`=0x1_0000_0004 (AW=34) and `out_cnt`=2.
- Max value: 4 beats of 0xFFFF_FFFF.
  - Expect `out_sum`=0x3_FFFF_FFFC with no overflow, and `out_cnt`=4.
- Backpressure: hold `out_ready`=0 for 5 cycles after a frame closes, while driving `in_valid`=1 with 7.
  - Expect `out_sum`/`out_cnt` stable.
  - Expect `in_ready`=0 and no accepts.
  - After `out_ready`=1, the next frame starts from 0.
- Reset mid-frame: accept 3 and 4, then assert `rst_n`=0 for 1 cycle, then send 1,1,1,1.
  - Expect `out_sum`=4 and `out_cnt`=4.
- Single-term frame: send 0 with `in_last`=1.
  - Expect `out_sum`=0 and `out_cnt`=1.
  - Also check that a gap in `in_valid` mid-frame does not change the result.

Source files
------------

// File: rtl/loba_pkg.sv
// loba_pkg: shared types and width helpers for the leading-one-based
// approximate multiplier family (loba0 multiplier, loba_acc accumulator).
//   state_t  : accumulator FSM state (ACC collecting, DONE holding result)
//   clog2    : ceil(log2(v)), clog2(1) = 0
//   aw_of    : accumulator width for LEN products of 2N bits (never overflows)
//   cw_of    : width of a 1..LEN term count
package loba_pkg;

    localparam int LOBA_N   = 16;  // default multiplier operand width
    localparam int LOBA_LEN = 8;   // default products per frame

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // LEN * (2^2N - 1) < 2^(2N + clog2(LEN)); LEN = 1 collapses to 2N.
    function automatic int aw_of(input int n, input int len);
        return 2 * n + clog2(len);
    endfunction

    function automatic int cw_of(input int len);
        return clog2(len + 1);
    endfunction

endpackage

// File: rtl/loba_acc.sv
// loba_acc: frame accumulator behind the loba0 approximate multiplier.
// Sums up to LEN unsigned 2N-bit products per frame; a frame closes on the
// LEN-th product or an accepted beat with in_last. The result is then held on
// a registered valid/ready output, and input is stalled until it is taken.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : product handshake (in_ready is Moore, = state ACC)
//   in_p, in_last        : product, frame-close marker (accepted beats only)
//   out_valid/out_ready  : result handshake (out_valid is Moore, = state DONE)
//   out_sum, out_cnt     : frame sum and term count, held until the next close
module loba_acc
    import loba_pkg::*;
#(
    parameter  int N   = LOBA_N,
    parameter  int LEN = LOBA_LEN,
    localparam int CW  = cw_of(LEN),
    localparam int AW  = aw_of(N, LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*N-1:0]  in_p,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_sum,
    output logic [CW-1:0]   out_cnt
);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   sum_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            accept;
    logic            close;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);

    assign accept  = in_valid & in_ready;
    assign sum_nxt = acc + AW'(in_p);
    assign cnt_nxt = cnt + CW'(1);
    // in_last and the length limit may coincide; either closes the frame once.
    assign close   = accept & (in_last | (cnt_nxt == CW'(LEN)));

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (close)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (close) begin
                    out_sum <= sum_nxt;
                    out_cnt <= cnt_nxt;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum_nxt;
                    cnt <= cnt_nxt;
                end
            end
        end
    end

endmodule
